// File: rtl/core85_simctl.sv
// Build option: define CORE85_TRACE_EN to build the opcode trace FIFO;
// with it undefined the trace outputs are tied off and trc_rd is ignored.

`ifdef CORE85_TRACE_EN
// Generic first-word-fall-through FIFO holding opcode trace entries.
// Latency: a pushed entry is visible on pop_dat right after the push edge.
// Backpressure: push at full is refused unless a pop frees a slot the same edge.
module core85_trace_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop_ok);
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end
endmodule
`endif

// Run controller for the 8085 core: power-on reset, opcode trace, HLT and timeout.
// Latency: core reset lifts RSTCYCLES clocks after rst; trace entry visible the edge rd_ rises.
// Backpressure: none toward the core; fetches meeting a full trace FIFO are dropped, trc_ovf set.
module core85_simctl #(
    parameter int                  DATASIZE   = 8,
    parameter int                  ADDRSIZE   = 16,
    parameter int                  RSTCYCLES  = 3,
    parameter int                  CYCSIZE    = 16,
    parameter int                  TIMEOUT    = 350,
    parameter logic [DATASIZE-1:0] HALTCODE   = 8'h76,
    parameter int                  HALTWAIT   = 2,
    parameter int                  TRACEDEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATASIZE-1:0]          addrdata,
    input  logic [ADDRSIZE-DATASIZE-1:0] addr,
    input  logic                         ale,
    input  logic                         iom_,
    input  logic                         s1,
    input  logic                         s0,
    input  logic                         rd_,
    input  logic                         wr_,
    output logic                         core_rst_,
    output logic                         running,
    output logic                         halted,
    output logic                         timeout,
    output logic                         done,
    output logic [CYCSIZE-1:0]           cycles,
    input  logic                         trc_rd,
    output logic [ADDRSIZE+DATASIZE-1:0] trc_data,
    output logic                         trc_empty,
    output logic                         trc_ovf
);
    localparam int                 RW        = $clog2(RSTCYCLES + 1);
    localparam int                 IW        = $clog2(HALTWAIT + 1);
    localparam logic [RW-1:0]      RST_LAST  = RW'(RSTCYCLES - 1);
    localparam logic [IW-1:0]      IDLE_LAST = IW'(HALTWAIT - 1);
    localparam logic [CYCSIZE-1:0] CYC_LAST  = CYCSIZE'(TIMEOUT - 1);
    localparam logic [2:0]         ST_FETCH  = 3'b011;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_RUN,
        ST_HWAIT,
        ST_HALT,
        ST_TOUT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [RW-1:0]      rst_cnt;
    logic [RW-1:0]      rst_cnt_nxt;
    logic [IW-1:0]      idle_cnt;
    logic [IW-1:0]      idle_cnt_nxt;
    logic [CYCSIZE-1:0] cycles_nxt;
    logic [CYCSIZE-1:0] cyc_inc;
    logic [DATASIZE-1:0] addr_lo;
    logic [DATASIZE-1:0] data_q;
    logic [2:0]         status;
    logic               rd_q;
    logic               mon_en;
    logic               fetch_done;
    logic               bus_idle;
    logic               at_budget;

    // Bus is only watched while the core is live and not yet stopped.
    assign mon_en     = (state == ST_RUN) || (state == ST_HWAIT);
    assign fetch_done = mon_en && (status == ST_FETCH) && !rd_q && rd_;
    assign bus_idle   = !ale && rd_ && wr_;
    assign at_budget  = (cycles == CYC_LAST);
    assign cyc_inc    = (cycles == '1) ? cycles : cycles + CYCSIZE'(1);

    // Next-state, reset-hold counter, halt idle counter and cycle budget.
    always_comb begin
        state_nxt    = state;
        rst_cnt_nxt  = rst_cnt;
        idle_cnt_nxt = idle_cnt;
        cycles_nxt   = cycles;
        case (state)
            ST_RESET: begin
                if (rst_cnt == RST_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    rst_cnt_nxt = rst_cnt + RW'(1);
                end
            end
            ST_RUN: begin
                cycles_nxt = cyc_inc;
                if (at_budget) begin
                    state_nxt = ST_TOUT;
                end else if (fetch_done && (data_q == HALTCODE)) begin
                    state_nxt    = ST_HWAIT;
                    idle_cnt_nxt = '0;
                end
            end
            ST_HWAIT: begin
                cycles_nxt   = cyc_inc;
                idle_cnt_nxt = bus_idle ? idle_cnt + IW'(1) : '0;
                // Halt completion outranks a budget expiring on the same edge.
                if (bus_idle && (idle_cnt == IDLE_LAST)) begin
                    state_nxt = ST_HALT;
                end else if (at_budget) begin
                    state_nxt = ST_TOUT;
                end else if (ale) begin
                    state_nxt = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RESET;
            rst_cnt  <= '0;
            idle_cnt <= '0;
            cycles   <= '0;
        end else begin
            state    <= state_nxt;
            rst_cnt  <= rst_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
            cycles   <= cycles_nxt;
        end
    end

    // Bus capture: low address and status on ALE, read data while rd_ is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_lo <= '0;
            status  <= '0;
            data_q  <= '0;
            rd_q    <= 1'b0;
        end else begin
            if (ale) begin
                addr_lo <= addrdata;
                status  <= {iom_, s1, s0};
            end
            if (!rd_) begin
                data_q <= addrdata;
            end
            rd_q <= rd_;
        end
    end

    assign core_rst_ = (state != ST_RESET);
    assign running   = (state == ST_RUN);
    assign halted    = (state == ST_HALT);
    assign timeout   = (state == ST_TOUT);
    assign done      = halted || timeout;

`ifdef CORE85_TRACE_EN
    typedef struct packed {
        logic [ADDRSIZE-DATASIZE-1:0] addr_hi;
        logic [DATASIZE-1:0]          addr_lo;
        logic [DATASIZE-1:0]          opcode;
    } trace_ent_t;

    trace_ent_t push_ent;
    logic       fifo_full;

    assign push_ent = '{addr_hi: addr, addr_lo: addr_lo, opcode: data_q};

    core85_trace_fifo #(
        .WIDTH (ADDRSIZE + DATASIZE),
        .DEPTH (TRACEDEPTH)
    ) u_trace_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fetch_done),
        .push_dat (push_ent),
        .pop      (trc_rd),
        .pop_dat  (trc_data),
        .empty    (trc_empty),
        .full     (fifo_full)
    );

    // Sticky overflow: a fetch arrived at a full FIFO with no pop to make room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trc_ovf <= 1'b0;
        end else if (fetch_done && fifo_full && !trc_rd) begin
            trc_ovf <= 1'b1;
        end
    end
`else
    logic unused_trace;

    assign unused_trace = ^{trc_rd, addr, addr_lo};
    assign trc_data     = '0;
    assign trc_empty    = 1'b1;
    assign trc_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_core85_simctl.sv
// Bench for core85_simctl: queue-based model checked every cycle plus literal spot checks.
module tb_core85_simctl;
    localparam int RSTC  = 3;
    localparam int TO    = 350;
    localparam int HW    = 2;
    localparam int DEPTH = 8;
`ifdef CORE85_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [7:0]  addrdata = 8'h00;
    logic [7:0]  addr     = 8'h00;
    logic        ale      = 1'b0;
    logic        iom_     = 1'b0;
    logic        s1       = 1'b0;
    logic        s0       = 1'b0;
    logic        rd_      = 1'b1;
    logic        wr_      = 1'b1;
    logic        trc_rd   = 1'b0;
    logic        core_rst_;
    logic        running;
    logic        halted;
    logic        timeout;
    logic        done;
    logic [15:0] cycles;
    logic [23:0] trc_data;
    logic        trc_empty;
    logic        trc_ovf;

    int checks = 0;
    int errors = 0;

    core85_simctl dut (
        .clk       (clk),
        .rst       (rst),
        .addrdata  (addrdata),
        .addr      (addr),
        .ale       (ale),
        .iom_      (iom_),
        .s1        (s1),
        .s0        (s0),
        .rd_       (rd_),
        .wr_       (wr_),
        .core_rst_ (core_rst_),
        .running   (running),
        .halted    (halted),
        .timeout   (timeout),
        .done      (done),
        .cycles    (cycles),
        .trc_rd    (trc_rd),
        .trc_data  (trc_data),
        .trc_empty (trc_empty),
        .trc_ovf   (trc_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_live = 1'b0;   // core out of reset
    bit          m_pend = 1'b0;   // HLT fetched, waiting for idle bus
    bit          m_halt = 1'b0;
    bit          m_tout = 1'b0;
    bit          m_ovf  = 1'b0;
    int          m_rel  = 0;
    int          m_idle = 0;
    int          m_cyc  = 0;
    logic [7:0]  m_lo   = 8'h00;
    logic [7:0]  m_dat  = 8'h00;
    logic [2:0]  m_st   = 3'b000;
    logic        m_rdq  = 1'b0;
    logic [23:0] m_q[$];
    bit          m_fetch;
    bit          m_pop;
    int          m_n0;
    logic [23:0] unused_pop;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_live = 1'b0; m_pend = 1'b0; m_halt = 1'b0; m_tout = 1'b0; m_ovf = 1'b0;
            m_rel = 0; m_idle = 0; m_cyc = 0;
            m_lo = 8'h00; m_dat = 8'h00; m_st = 3'b000; m_rdq = 1'b0;
            m_q.delete();
        end else begin
            m_fetch = m_live && !m_halt && !m_tout && (m_st == 3'b011) && !m_rdq && rd_;
            m_pop   = TRACE && trc_rd && (m_q.size() != 0);
            m_n0    = m_q.size();
            if (m_pop) unused_pop = m_q.pop_front();
            if (TRACE && m_fetch) begin
                if (m_n0 == DEPTH && !m_pop) m_ovf = 1'b1;
                else m_q.push_back({addr, m_lo, m_dat});
            end
            if (!m_live) begin
                m_rel++;
                m_live = (m_rel == RSTC);
            end else if (!m_halt && !m_tout) begin
                m_cyc++;
                if (m_pend) begin
                    m_idle = (!ale && rd_ && wr_) ? m_idle + 1 : 0;
                    if (m_idle == HW) m_halt = 1'b1;
                    else if (m_cyc == TO) m_tout = 1'b1;
                    else if (ale) m_pend = 1'b0;
                end else if (m_cyc == TO) begin
                    m_tout = 1'b1;
                end else if (m_fetch && m_dat == 8'h76) begin
                    m_pend = 1'b1;
                    m_idle = 0;
                end
            end
            if (ale) begin
                m_lo = addrdata;
                m_st = {iom_, s1, s0};
            end
            if (!rd_) m_dat = addrdata;
            m_rdq = rd_;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("core_rst_", 64'(core_rst_), 64'(m_live));
        chk("running",   64'(running),   64'(m_live && !m_pend && !m_halt && !m_tout));
        chk("halted",    64'(halted),    64'(m_halt));
        chk("timeout",   64'(timeout),   64'(m_tout));
        chk("done",      64'(done),      64'(m_halt || m_tout));
        chk("cycles",    64'(cycles),    64'(m_cyc));
        chk("trc_empty", 64'(trc_empty), 64'(m_q.size() == 0));
        chk("trc_data",  64'(trc_data),  64'((m_q.size() == 0) ? 24'h0 : m_q[0]));
        chk("trc_ovf",   64'(trc_ovf),   64'(m_ovf));
    end

    // ---------------- stimulus ----------------
    // Opcode fetch cycle: ALE with status 011, rd_ low two clocks, then rd_ high.
    task automatic fetch(input logic [15:0] a, input logic [7:0] op, input bit pop_at_push);
        ale = 1'b1; addrdata = a[7:0]; addr = a[15:8]; {iom_, s1, s0} = 3'b011;
        @(negedge clk);
        ale = 1'b0; rd_ = 1'b0; addrdata = op;
        @(negedge clk);
        @(negedge clk);
        rd_ = 1'b1; trc_rd = pop_at_push;
        @(negedge clk);
        trc_rd = 1'b0; {iom_, s1, s0} = 3'b000;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("reset_core_rst_", 64'(core_rst_), 64'(0));
        chk("reset_trc_empty", 64'(trc_empty), 64'(1));
        chk("reset_cycles",    64'(cycles),    64'(0));

        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("core_rst_hold", 64'(core_rst_), 64'(0));
        @(negedge clk);
        chk("core_rst_rise", 64'(core_rst_), 64'(1));
        chk("run_entry",     64'(running),   64'(1));
        chk("cycles_first",  64'(cycles),    64'(0));
        @(negedge clk);
        chk("cycles_second", 64'(cycles),    64'(1));

        // Single fetch then pop, then a pop on an empty FIFO.
        fetch(16'h0000, 8'h3E, 1'b0);
        chk("fetch_data",  64'(trc_data),  64'(TRACE ? 24'h00003E : 24'h0));
        chk("fetch_empty", 64'(trc_empty), 64'(!TRACE));
        trc_rd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        trc_rd = 1'b0;
        chk("pop_empty", 64'(trc_empty), 64'(1));

        // Fill to depth, push+pop at full, then one overflowing fetch.
        for (int i = 0; i < DEPTH; i++) begin
            fetch(16'h1000 + 16'(i), 8'h10 + 8'(i), 1'b0);
        end
        chk("full_no_ovf", 64'(trc_ovf),  64'(0));
        chk("full_head",   64'(trc_data), 64'(TRACE ? 24'h100010 : 24'h0));
        fetch(16'h1008, 8'h18, 1'b1);
        chk("pushpop_no_ovf", 64'(trc_ovf),  64'(0));
        chk("pushpop_head",   64'(trc_data), 64'(TRACE ? 24'h100111 : 24'h0));
        fetch(16'h1009, 8'h19, 1'b0);
        chk("overflow", 64'(trc_ovf), 64'(TRACE));
        trc_rd = 1'b1;
        repeat (DEPTH) @(negedge clk);
        trc_rd = 1'b0;
        chk("drained", 64'(trc_empty), 64'(1));

        // HLT fetch interrupted by ALE, then a real halt.
        fetch(16'h0004, 8'h76, 1'b0);
        @(negedge clk);
        chk("hwait_not_running", 64'(running), 64'(0));
        fetch(16'h0006, 8'h00, 1'b0);
        chk("hwait_exit", 64'(running), 64'(1));
        fetch(16'h0005, 8'h76, 1'b0);
        @(negedge clk);
        chk("halt_early", 64'(halted), 64'(0));
        @(negedge clk);
        chk("halted",      64'(halted),  64'(1));
        chk("halt_done",   64'(done),    64'(1));
        chk("halt_no_tout", 64'(timeout), 64'(0));
        fetch(16'h0007, 8'h3E, 1'b0);
        chk("halt_head", 64'(trc_data), 64'(TRACE ? 24'h000476 : 24'h0));
        trc_rd = 1'b1;
        @(negedge clk);
        trc_rd = 1'b0;
        chk("halt_pop", 64'(trc_data), 64'(TRACE ? 24'h000600 : 24'h0));

        // Asynchronous reset mid-run clears everything immediately.
        #3 rst = 1'b1;
        #1;
        chk("arst_halted",    64'(halted),    64'(0));
        chk("arst_core_rst_", 64'(core_rst_), 64'(0));
        chk("arst_empty",     64'(trc_empty), 64'(1));
        chk("arst_cycles",    64'(cycles),    64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (RSTC) @(negedge clk);
        chk("rerun", 64'(running), 64'(1));

        // Idle run until the cycle budget expires (bounded wait).
        for (int k = 0; k < 500; k++) begin
            if (timeout) break;
            @(negedge clk);
        end
        chk("timeout_reached", 64'(timeout), 64'(1));
        chk("timeout_cycles",  64'(cycles),  64'(16'd350));
        chk("timeout_done",    64'(done),    64'(1));
        chk("timeout_no_halt", 64'(halted),  64'(0));
        fetch(16'h0100, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        chk("tout_frozen", 64'(cycles),    64'(16'd350));
        chk("tout_no_push", 64'(trc_empty), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
